// File: rtl/axis_frame_sel_ctrl.sv
`default_nettype none
// ============================================================================
// axis_frame_sel_ctrl : frame-aligned raw/Sobel mux select from a debounced switch
// Rev 1.0 - initial release
// ============================================================================
module axis_frame_sel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SYNC_STAGES     = 2,
  parameter int V_LINES         = 480
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic sw_in,
  input  logic s_axis_tvalid,
  input  logic s_axis_tready,
  input  logic s_axis_tuser,
  input  logic s_axis_tlast,
  output logic sel,
  output logic sel_pending,
  output logic sel_changed,
  output logic frame_done
);

  localparam int c_cnt_w  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_line_w = $clog2(V_LINES + 1);

  typedef enum logic [0:0] {
    LOCKED  = 1'b0,
    PENDING = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sw_s;
  logic                   r_stable;
  logic [c_cnt_w-1:0]     r_db_cnt;
  logic [c_line_w-1:0]    r_line_cnt;
  logic [c_line_w-1:0]    w_line_nxt;
  logic                   w_beat;
  logic                   w_eof;
  state_t                 r_state;

  assign w_sw_s = r_sync[SYNC_STAGES-1];
  assign w_beat = s_axis_tvalid & s_axis_tready;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sw_in};
    end
  end

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_stable <= 1'b0;
      r_db_cnt <= '0;
    end else if (w_sw_s == r_stable) begin
      r_db_cnt <= '0;
    end else if (r_db_cnt == c_cnt_w'(DEBOUNCE_CYCLES - 1)) begin
      r_stable <= w_sw_s;
      r_db_cnt <= '0;
    end else begin
      r_db_cnt <= r_db_cnt + c_cnt_w'(1);
    end
  end

  always_comb begin
    w_eof      = 1'b0;
    w_line_nxt = r_line_cnt;
    if (w_beat) begin
      if (s_axis_tuser && s_axis_tlast) begin
        // Single-beat-line SOF: this beat already closes line 0.
        if (V_LINES == 1) begin
          w_eof      = 1'b1;
          w_line_nxt = '0;
        end else begin
          w_line_nxt = c_line_w'(1);
        end
      end else if (s_axis_tuser) begin
        w_line_nxt = '0;
      end else if (s_axis_tlast) begin
        if (r_line_cnt == c_line_w'(V_LINES - 1)) begin
          w_eof      = 1'b1;
          w_line_nxt = '0;
        end else begin
          w_line_nxt = r_line_cnt + c_line_w'(1);
        end
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_line_cnt <= '0;
      frame_done <= 1'b0;
    end else begin
      r_line_cnt <= w_line_nxt;
      frame_done <= w_eof;
    end
  end

  // The commit compares against the registered stable value, so a request
  // accepted on the EOF beat itself waits for the following frame.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state     <= LOCKED;
      sel         <= 1'b0;
      sel_pending <= 1'b0;
      sel_changed <= 1'b0;
    end else begin
      sel_changed <= 1'b0;
      case (r_state)
        LOCKED: begin
          if (r_stable != sel) begin
            r_state     <= PENDING;
            sel_pending <= 1'b1;
          end
        end
        PENDING: begin
          if (r_stable == sel) begin
            r_state     <= LOCKED;
            sel_pending <= 1'b0;
          end else if (w_eof) begin
            sel         <= r_stable;
            sel_changed <= 1'b1;
            r_state     <= LOCKED;
            sel_pending <= 1'b0;
          end
        end
        default: begin
          r_state     <= LOCKED;
          sel_pending <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
